// File: rtl/restoring_div_8_if.sv
// Start/done handshake and operand/result bus for the iterative restoring divider.
interface restoring_div_8_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_div_8.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with a
// WIDTH+1-bit trial subtract built from 4-bit borrow-lookahead groups.
module restoring_div_8 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    restoring_div_8_if.slave   bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned NG = WIDTH / 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   r_iter;
    logic             qbit;
    logic             start_ok;

    // a - {0,b}; within a group borrows ripple, across groups they use group generate/propagate
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] res;
        logic [3:0]     ax, bx, g, p;
        logic           bin, bg, gg, gp;
        res = '0;
        bin = 1'b0;
        for (int gi = 0; gi < NG; gi++) begin
            ax = a[gi*4 +: 4];
            bx = b[gi*4 +: 4];
            g  = ~ax & bx;
            p  = ~(ax ^ bx);
            bg = bin;
            for (int j = 0; j < 4; j++) begin
                res[gi*4 + j] = ax[j] ^ bx[j] ^ bg;
                bg            = g[j] | (p[j] & bg);
            end
            gg  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
            gp  = &p;
            bin = gg | (gp & bin);
        end
        res[WIDTH] = a[WIDTH] ^ bin;
        return res;
    endfunction

    // One iteration: shift in next dividend bit, keep the difference if it did not borrow
    always_comb begin
        rs     = {r_q[WIDTH-1:0], d_q[WIDTH-1]};
        t      = trial_sub(rs, v_q);
        qbit   = ~t[WIDTH];
        r_iter = qbit ? t : rs;
    end

    assign start_ok = bus.start && (state_q != CALC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        v_d     = v_q;
        r_d     = r_q;
        qs_d    = qs_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        unique case (state_q)
            CALC: begin
                if (zero_q) begin
                    // Zero divisor: a single pass-through cycle, no iterations
                    quot_d  = '1;
                    rem_d   = d_q;
                    dz_d    = 1'b1;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    r_d  = r_iter;
                    qs_d = {qs_q[WIDTH-2:0], qbit};
                    d_d  = {d_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == CW'(0)) begin
                        quot_d  = {qs_q[WIDTH-2:0], qbit};
                        rem_d   = r_iter[WIDTH-1:0];
                        dz_d    = 1'b0;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                if (start_ok) begin
                    d_d     = bus.dividend;
                    v_d     = bus.divisor;
                    r_d     = '0;
                    qs_d    = '0;
                    zero_d  = (bus.divisor == '0);
                    cnt_d   = (bus.divisor == '0) ? CW'(0) : CW'(WIDTH - 1);
                    state_d = CALC;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            qs_q    <= '0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            v_q     <= v_d;
            r_q     <= r_d;
            qs_q    <= qs_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_restoring_div_8.sv
// Self-checking bench for restoring_div_8: latency/result model plus directed and random operations.
module tb_restoring_div_8;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    restoring_div_8_if #(.WIDTH(WIDTH)) bus();
    restoring_div_8 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int failures = 0;
    bit checking_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an operation completes a fixed number of edges after acceptance
    int         remaining = 0;
    logic       m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [7:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0, p_a = '0, p_b = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining = 0;
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
            m_q = '0; m_r = '0;
        end else begin
            m_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    m_done = 1'b1;
                    m_q = p_q; m_r = p_r; m_dz = p_dz;
                end
            end else if (bus.start) begin
                p_a = bus.dividend;
                p_b = bus.divisor;
                if (p_b == 8'd0) begin
                    p_q = 8'hFF; p_r = p_a; p_dz = 1'b1; remaining = 1;
                end else begin
                    p_q = p_a / p_b; p_r = p_a % p_b; p_dz = 1'b0; remaining = WIDTH;
                end
            end
            m_busy = (remaining > 0);
        end
    end

    // Per-cycle comparison against the model, plus the division invariant on completion
    always @(negedge clk) begin
        if (rst_n && checking_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("quotient", 32'(bus.quotient), 32'(m_q));
            check("remainder", 32'(bus.remainder), 32'(m_r));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dz));
            if (bus.done && !m_dz) begin
                check("invariant", 32'(bus.quotient) * 32'(p_b) + 32'(bus.remainder), 32'(p_a));
                check("rem_lt_div", 32'(bus.remainder < p_b), 32'd1);
            end
        end
    end

    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor = 8'($urandom);
    endtask

    task automatic wait_done(input string name, output int n);
        bit found = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.done) found = 1'b1;
        end
        check({name, "_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input logic [7:0] q, input logic [7:0] r, input logic dz);
        int n;
        start_op(a, b);
        wait_done(name, n);
        check({name, "_lat"}, 32'(n), 32'(lat));
        check({name, "_q"}, 32'(bus.quotient), 32'(q));
        check({name, "_r"}, 32'(bus.remainder), 32'(r));
        check({name, "_dz"}, 32'(bus.div_by_zero), 32'(dz));
    endtask

    initial begin
        int n;
        logic [7:0] a, b;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
        check("rst_dz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        checking_en = 1'b1;
        @(posedge clk); #1;

        run_op("d200_7", 8'd200, 8'd7, 8, 8'd28, 8'd4, 1'b0);
        check("model_pin_q", 32'(m_q), 32'd28);
        check("model_pin_r", 32'(m_r), 32'd4);
        run_op("d255_1", 8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0);
        run_op("d5_9", 8'd5, 8'd9, 8, 8'd0, 8'd5, 1'b0);
        run_op("d255_255", 8'd255, 8'd255, 8, 8'd1, 8'd0, 1'b0);
        run_op("d77_0", 8'd77, 8'd0, 1, 8'd255, 8'd77, 1'b1);
        check("model_pin_dz", 32'(m_dz), 32'd1);
        run_op("d10_3", 8'd10, 8'd3, 8, 8'd3, 8'd1, 1'b0);

        // Start pulsed mid-operation is ignored
        start_op(8'd100, 8'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("ignored", n);
        check("ignored_lat", 32'(n), 32'd5);
        check("ignored_q", 32'(bus.quotient), 32'd11);
        check("ignored_r", 32'(bus.remainder), 32'd1);

        // Back-to-back: start held in the done cycle
        start_op(8'd100, 8'd9);
        wait_done("b2b_first", n);
        check("b2b_first_lat", 32'(n), 32'd8);
        start_op(8'd240, 8'd16);
        check("b2b_no_bubble", 32'(bus.busy), 32'd1);
        wait_done("b2b_second", n);
        check("b2b_second_lat", 32'(n), 32'd8);
        check("b2b_q", 32'(bus.quotient), 32'd15);
        check("b2b_r", 32'(bus.remainder), 32'd0);

        // Reset in the middle of a calculation
        start_op(8'd200, 8'd7);
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_q", 32'(bus.quotient), 32'd0);
        check("midrst_r", 32'(bus.remainder), 32'd0);
        check("midrst_dz", 32'(bus.div_by_zero), 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("d9_2", 8'd9, 8'd2, 8, 8'd4, 8'd1, 1'b0);

        // Random sweep, with occasional zero divisors and back-to-back starts
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            start_op(a, b);
            wait_done("rand", n);
            check("rand_lat", 32'(n), (b == 8'd0) ? 32'd1 : 32'd8);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
